// File: rtl/cache_pkg.sv
// Shared definitions for the data cache stage: miss FSM encoding, address-split widths, counter helper.
package cache_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_EVICT = 2'd1;
  localparam logic [1:0] ST_FILL  = 2'd2;

  function automatic int off_w(input int line_bytes);
    return $clog2(line_bytes);
  endfunction

  function automatic int idx_w(input int num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int tag_w(input int addr_w, input int num_lines, input int line_bytes);
    return addr_w - $clog2(num_lines) - $clog2(line_bytes);
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/cache_line_array.sv
// Tag/valid/dirty/data storage for the direct-mapped data cache.
// One read port, a 1-2 byte store port and a full-line fill port sharing the same index.
module cache_line_array
  import cache_pkg::*;
#(
  parameter int NUM_LINES  = 4,
  parameter int LINE_BYTES = 32,
  parameter int IDX_W      = idx_w(NUM_LINES),
  parameter int OFF_W      = off_w(LINE_BYTES),
  parameter int TAG_W      = tag_w(16, NUM_LINES, LINE_BYTES)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [IDX_W-1:0]        idx,
  output logic                    rd_valid,
  output logic                    rd_dirty,
  output logic [TAG_W-1:0]        rd_tag,
  output logic [LINE_BYTES*8-1:0] rd_line,
  input  logic                    bw_en,
  input  logic                    bw_word,
  input  logic [OFF_W-1:0]        bw_off,
  input  logic [15:0]             bw_data,
  input  logic                    lw_en,
  input  logic [TAG_W-1:0]        lw_tag,
  input  logic [LINE_BYTES*8-1:0] lw_line
);

  localparam int LINE_W = LINE_BYTES * 8;

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [LINE_W-1:0]    data_q [NUM_LINES];
  logic [OFF_W-1:0]     off_hi;

  assign rd_valid = valid_q[idx];
  assign rd_dirty = dirty_q[idx];
  assign rd_tag   = tag_q[idx];
  assign rd_line  = data_q[idx];
  assign off_hi   = {bw_off[OFF_W-1:1], 1'b1};

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (lw_en) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (bw_en) begin
      dirty_q[idx] <= 1'b1;
    end
  end

  // Contents are not reset; valid_q alone decides whether a line may hit.
  always_ff @(posedge clk) begin
    if (lw_en) begin
      tag_q[idx]  <= lw_tag;
      data_q[idx] <= lw_line;
    end else if (bw_en) begin
      for (int b = 0; b < LINE_BYTES; b++) begin
        if (OFF_W'(b) == bw_off)
          data_q[idx][b*8 +: 8] <= bw_data[7:0];
        else if (bw_word && (OFF_W'(b) == off_hi))
          data_q[idx][b*8 +: 8] <= bw_data[15:8];
      end
    end
  end

endmodule

// File: rtl/data_cache_stage.sv
// Memory-access pipeline stage with a direct-mapped, write-back, write-allocate data cache.
// Define DATA_CACHE_PERF_EN to add saturating hit/miss/evict counters.
module data_cache_stage
  import cache_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int WORD_W     = 16,
  parameter int NUM_LINES  = 4,
  parameter int LINE_BYTES = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable_cache,
  input  logic [ADDR_W-1:0]       tlb_result,
  input  logic [WORD_W-1:0]       dataReg,
  input  logic [1:0]              ldSt_enable,
  input  logic                    word_access_in,
  input  logic [2:0]              destReg_addr_in,
  input  logic                    we_in,
  input  logic [1:0]              bp_in,
  output logic [WORD_W-1:0]       cache_result,
  output logic [2:0]              destReg_addr_out,
  output logic                    we_out,
  output logic [1:0]              bp_out,
  output logic                    word_access,
  output logic                    stall,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [LINE_BYTES*8-1:0] mem_wdata,
  input  logic [LINE_BYTES*8-1:0] mem_rdata,
  input  logic                    mem_ack
`ifdef DATA_CACHE_PERF_EN
  ,
  output logic [31:0]             hit_count,
  output logic [31:0]             miss_count,
  output logic [31:0]             evict_count
`endif
);

  localparam int OFF_W  = off_w(LINE_BYTES);
  localparam int IDX_W  = idx_w(NUM_LINES);
  localparam int TAG_W  = tag_w(ADDR_W, NUM_LINES, LINE_BYTES);
  localparam int LINE_W = LINE_BYTES * 8;

  logic [ADDR_W-1:0] tlb_result_q;
  logic [WORD_W-1:0] data_q;
  logic [1:0]        ldst_q;
  logic              word_q;
  logic [2:0]        dest_q;
  logic              we_q;
  logic [1:0]        bp_q;
  logic              load_en;

  logic [1:0] state_q, state_d;
  logic       ack_gap_q;
  logic       ack_ok;

  logic [OFF_W-1:0]  off, eff_off;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic              is_load, is_store, mem_op, hit, miss;
  logic              rd_valid, rd_dirty;
  logic [TAG_W-1:0]  rd_tag;
  logic [LINE_W-1:0] rd_line;
  logic [7:0]        byte0, byte1;
  logic signed [WORD_W-1:0] byte_sx;
  logic [WORD_W-1:0] load_data;
  logic              bw_en, lw_en;

  assign load_en = enable_cache & ~stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      tlb_result_q <= '0;
      data_q       <= '0;
      ldst_q       <= '0;
      word_q       <= 1'b0;
      dest_q       <= '0;
      we_q         <= 1'b0;
      bp_q         <= '0;
    end else if (load_en) begin
      tlb_result_q <= tlb_result;
      data_q       <= dataReg;
      ldst_q       <= ldSt_enable;
      word_q       <= word_access_in;
      dest_q       <= destReg_addr_in;
      we_q         <= we_in;
      bp_q         <= bp_in;
    end
  end

  assign off      = tlb_result_q[OFF_W-1:0];
  assign idx      = tlb_result_q[OFF_W +: IDX_W];
  assign tag      = tlb_result_q[ADDR_W-1 -: TAG_W];
  assign eff_off  = word_q ? {off[OFF_W-1:1], 1'b0} : off;
  assign is_load  = ldst_q[1];
  assign is_store = ldst_q[0];
  assign mem_op   = is_load | is_store;
  assign hit      = mem_op & rd_valid & (rd_tag == tag);
  assign miss     = mem_op & ~hit;

  assign stall = miss | (state_q != ST_IDLE);

  // A completed transfer forces one idle request cycle, also between evict and fill.
  assign mem_req = (state_q != ST_IDLE) & ~ack_gap_q;
  assign ack_ok  = mem_ack & mem_req;
  assign mem_we  = (state_q == ST_EVICT);

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    if (state_q == ST_EVICT) begin
      mem_addr  = {rd_tag, idx, {OFF_W{1'b0}}};
      mem_wdata = rd_line;
    end else if (state_q == ST_FILL) begin
      mem_addr  = {tag, idx, {OFF_W{1'b0}}};
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (miss) state_d = (rd_valid & rd_dirty) ? ST_EVICT : ST_FILL;
      ST_EVICT: if (ack_ok) state_d = ST_FILL;
      ST_FILL:  if (ack_ok) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ack_gap_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ack_gap_q <= ack_ok;
    end
  end

  assign bw_en = is_store & ~stall;
  assign lw_en = (state_q == ST_FILL) & ack_ok;

  cache_line_array #(
    .NUM_LINES  (NUM_LINES),
    .LINE_BYTES (LINE_BYTES),
    .IDX_W      (IDX_W),
    .OFF_W      (OFF_W),
    .TAG_W      (TAG_W)
  ) u_lines (
    .clk      (clk),
    .reset    (reset),
    .idx      (idx),
    .rd_valid (rd_valid),
    .rd_dirty (rd_dirty),
    .rd_tag   (rd_tag),
    .rd_line  (rd_line),
    .bw_en    (bw_en),
    .bw_word  (word_q),
    .bw_off   (eff_off),
    .bw_data  (data_q[15:0]),
    .lw_en    (lw_en),
    .lw_tag   (tag),
    .lw_line  (mem_rdata)
  );

  // Little-endian: the byte at the (word-aligned) offset is the low byte.
  always_comb begin
    byte0     = rd_line[{eff_off, 3'b000} +: 8];
    byte1     = rd_line[{eff_off[OFF_W-1:1], 1'b1, 3'b000} +: 8];
    byte_sx   = WORD_W'($signed(byte0));
    load_data = word_q ? WORD_W'({byte1, byte0}) : byte_sx;
  end

  assign cache_result     = is_load ? load_data : WORD_W'(tlb_result_q);
  assign destReg_addr_out = dest_q;
  assign we_out           = we_q & ~stall;
  assign bp_out           = bp_q;
  assign word_access      = word_q;

`ifdef DATA_CACHE_PERF_EN
  // counted_q keeps a held instruction, or its post-fill replay, from counting again.
  logic counted_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      counted_q   <= 1'b0;
      hit_count   <= '0;
      miss_count  <= '0;
      evict_count <= '0;
    end else begin
      if (load_en)
        counted_q <= 1'b0;
      else if (lw_en || (hit && !stall))
        counted_q <= 1'b1;
      if (hit && !stall && !counted_q)
        hit_count <= sat_inc32(hit_count);
      if ((state_q == ST_IDLE) && miss)
        miss_count <= sat_inc32(miss_count);
      if ((state_q == ST_EVICT) && ack_ok)
        evict_count <= sat_inc32(evict_count);
    end
  end
`endif

endmodule
